// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing types and constants for the TX/RX paths.
package uart_pkg;
    localparam int IDX_W         = 4;
    localparam int DEFAULT_DIV_C = 10416;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction
endpackage

// File: rtl/uart_div_counter.sv
// uart_div_counter: per-bit cycle counter with clear/hold/advance, flags wrap, half-point and zero.
module uart_div_counter #(
    parameter int DIV_W = 16
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIV_W-1:0] div,
    output logic             wrap,
    output logic             half,
    output logic             zero
);
    logic [DIV_W-1:0] cyc_q, cyc_d;
    always_comb begin
        wrap  = cyc_q == div - DIV_W'(1);
        half  = cyc_q == (div >> 1) - DIV_W'(1);
        zero  = cyc_q == '0;
        cyc_d = clear ? '0 : advance ? (wrap ? '0 : cyc_q + DIV_W'(1)) : cyc_q;
    end
    always_ff @(posedge sysclk or posedge reset)
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
endmodule

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: UART bit-timing engine emitting one tick per frame bit and a finish pulse.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = DEFAULT_DIV_C,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             enable,
    input  logic             mode,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             abort,
    output logic             bit_tick,
    output logic [IDX_W-1:0] bit_index,
    output logic             busy,
    output logic             finish
);
    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_BITS - 1);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d, fin_q, fin_d;
    logic             start, step, done, wrap, half, zero;
    uart_div_counter #(.DIV_W(DIV_W)) u_cnt (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (state_q == IDLE),
        .advance(step),
        .div    (div_q),
        .wrap   (wrap),
        .half   (half),
        .zero   (zero)
    );
    always_ff @(posedge sysclk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            div_q   <= DIV_W'(DEFAULT_DIV);
            idx_q   <= '0;
            mode_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            fin_q   <= fin_d;
        end
    // abort outranks both pause and completion
    always_comb begin
        start   = state_q == IDLE && trigger && enable;
        step    = state_q == RUN && enable && !abort;
        done    = step && wrap && idx_q == LAST;
        state_d = state_q == IDLE ? (start ? RUN : IDLE) : ((abort || done) ? IDLE : RUN);
        div_d   = start ? (baud_div < DIV_W'(2) ? DIV_W'(DEFAULT_DIV) : baud_div) : div_q;
        mode_d  = start ? mode : mode_q;
        idx_d   = (start || abort || done) ? '0 : (step && wrap) ? idx_q + IDX_W'(1) : idx_q;
        fin_d   = done;
    end
    // tick is gated by step so a tick point held during a pause fires once on resume
    always_comb begin
        busy      = state_q == RUN;
        bit_tick  = step && (mode_q ? half : zero);
        bit_index = idx_q;
        finish    = fin_q;
    end
endmodule
